universal_register: RTL

Parametrised multi-mode register, the next generation of the team's single-bit D flip-flop with Set/Reset. It holds a WIDTH-bit word and, per clock, holds, loads, shifts, rotates, increments or decrements it, with a registered carry/shift-out bit and a zero flag. It is the general storage element for datapath registers, shift chains and small counters in the lab designs.

---
 rtl/universal_register.sv | 104 ++++++++++
 1 files changed

// File: rtl/universal_register.sv
// Multi-mode WIDTH-bit register: hold, load, shift, rotate, increment and decrement,
// with a registered carry/shift-out bit and a combinational zero flag.
module universal_register #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [31:0] SET_VALUE   = 32'hFFFF_FFFF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Set,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SinL,
  input  logic             SinR,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             Zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SET_VAL = SET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic [WIDTH-1:0] w_q_next;
  logic             w_cout_next;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  // Top bit of the (WIDTH+1)-bit result is the carry out of INC or the borrow out of DEC.
  assign w_sum  = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_q_next    = r_q;
    w_cout_next = r_cout;
    case (Mode)
      MODE_HOLD: begin
        w_q_next    = r_q;
        w_cout_next = r_cout;
      end
      MODE_LOAD: begin
        w_q_next    = D;
        w_cout_next = 1'b0;
      end
      MODE_SHL: begin
        w_q_next    = {r_q[WIDTH-2:0], SinL};
        w_cout_next = r_q[WIDTH-1];
      end
      MODE_SHR: begin
        w_q_next    = {SinR, r_q[WIDTH-1:1]};
        w_cout_next = r_q[0];
      end
      MODE_ROL: begin
        w_q_next    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_cout_next = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_q_next    = {r_q[0], r_q[WIDTH-1:1]};
        w_cout_next = r_q[0];
      end
      MODE_INC: begin
        w_q_next    = w_sum[WIDTH-1:0];
        w_cout_next = w_sum[WIDTH];
      end
      MODE_DEC: begin
        w_q_next    = w_diff[WIDTH-1:0];
        w_cout_next = w_diff[WIDTH];
      end
      default: begin
        w_q_next    = r_q;
        w_cout_next = r_cout;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_q    <= RST_VAL;
      r_cout <= 1'b0;
    end else if (Set) begin
      r_q    <= SET_VAL;
      r_cout <= 1'b0;
    end else if (En) begin
      r_q    <= w_q_next;
      r_cout <= w_cout_next;
    end
  end

  assign Q    = r_q;
  assign Cout = r_cout;
  assign Zero = ~|r_q;

endmodule
